// File: rtl/alu_rv32im_pkg.sv
// Shared constants and operation encodings for the RV32IM execute-stage ALU.
// No ports; imported by alu_rv32im and alu_mul.
// The multiply ops (ALU_MUL..ALU_MULHU) only produce results when the design
// is built with ALU_MEXT_EN defined.
package alu_rv32im_pkg;

  // Operand/result width; only 32 is supported.
  localparam int unsigned DATA_W  = 32;
  // Shift amount width, taken from B[4:0].
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned OP_W    = 5;
  localparam int unsigned PROD_W  = 2 * DATA_W;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_CPY    = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14
  } alu_op_e;

endpackage

// File: rtl/alu_mul.sv
// Combinational 32x32 multiplier with per-operand signedness.
// Ports:
//   A, B      : 32-bit operands
//   a_signed  : treat A as two's complement when set, unsigned otherwise
//   b_signed  : treat B as two's complement when set, unsigned otherwise
//   product   : full 64-bit product
// Only instantiated when ALU_MEXT_EN is defined.
module alu_mul
  import alu_rv32im_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              a_signed,
  input  logic              b_signed,
  output logic [PROD_W-1:0] product
);

  // Extending each operand by one bit (sign or zero) lets a single signed
  // 33x33 multiply serve all four signedness combinations.
  logic signed [DATA_W:0]     a_ext;
  logic signed [DATA_W:0]     b_ext;
  logic signed [2*DATA_W+1:0] full;

  always_comb begin
    a_ext   = $signed({a_signed & A[DATA_W-1], A});
    b_ext   = $signed({b_signed & B[DATA_W-1], B});
    full    = (2*DATA_W+2)'(a_ext) * (2*DATA_W+2)'(b_ext);
    product = full[PROD_W-1:0];
  end

endmodule

// File: rtl/alu_rv32im.sv
// Registered integer ALU for the RV32IM execute stage.
// Ports:
//   clock   : rising-edge clock
//   reset   : asynchronous active-low reset, clears result
//   A, B    : 32-bit operands (rs1, rs2/immediate)
//   ALUCode : 5-bit operation select (alu_op_e); unused codes give 0
//   result  : registered result, one cycle after the inputs are sampled
// Build option: define ALU_MEXT_EN to enable MUL/MULH/MULHSU/MULHU; without
// it no multiplier exists and those codes behave like unused codes.
module alu_rv32im
  import alu_rv32im_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [OP_W-1:0]   ALUCode,
  output logic [DATA_W-1:0] result
);

  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0]  next_result;

  assign shamt = B[SHAMT_W-1:0];

`ifdef ALU_MEXT_EN
  logic              a_signed;
  logic              b_signed;
  logic [PROD_W-1:0] product;

  // Operand signedness for the high-half multiplies; MUL's low half is
  // independent of signedness.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (ALUCode)
      ALU_MULH: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      ALU_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
  end

  alu_mul u_mul (
    .A        (A),
    .B        (B),
    .a_signed (a_signed),
    .b_signed (b_signed),
    .product  (product)
  );
`endif

  // Operation select ahead of the result register.
  always_comb begin
    next_result = '0;
    case (ALUCode)
      ALU_ADD:  next_result = A + B;
      ALU_SUB:  next_result = A - B;
      ALU_SLL:  next_result = A << shamt;
      ALU_SLT:  next_result = {(DATA_W-1)'(0), $signed(A) < $signed(B)};
      ALU_SLTU: next_result = {(DATA_W-1)'(0), A < B};
      ALU_XOR:  next_result = A ^ B;
      ALU_SRL:  next_result = A >> shamt;
      ALU_SRA:  next_result = DATA_W'($signed(A) >>> shamt);
      ALU_OR:   next_result = A | B;
      ALU_AND:  next_result = A & B;
      ALU_CPY:  next_result = B;
`ifdef ALU_MEXT_EN
      ALU_MUL:    next_result = product[DATA_W-1:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  next_result = product[PROD_W-1:DATA_W];
`endif
      default:  next_result = '0;
    endcase
  end

  // Single result register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) result <= '0;
    else        result <= next_result;
  end

endmodule

// File: tb/tb_alu_rv32im.sv
// Self-checking bench for alu_rv32im: directed steps followed by randomized
// operations compared against an arithmetic reference model.
module tb_alu_rv32im;

  logic        clock;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  ALUCode;
  logic [31:0] result;

  int unsigned total;
  int unsigned passed;

  alu_rv32im dut (
    .clock   (clock),
    .reset   (reset),
    .A       (A),
    .B       (B),
    .ALUCode (ALUCode),
    .result  (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: integer arithmetic straight from the operation rules.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] op);
    longint sa, sb, ua, ub, d, q;
    logic [63:0] p;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sh = int'(b % 32);
    d  = longint'(1) << sh;
    case (op)
      5'd0:  return 32'(ua + ub);
      5'd1:  return 32'(ua - ub);
      5'd2:  return 32'(ua * d);
      5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  return (ua < ub) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return 32'(ua / d);
      5'd7: begin
        q = sa / d;
        if (sa < 0 && (sa % d) != 0) q = q - 1;
        return 32'(q);
      end
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: return b;
`ifdef ALU_MEXT_EN
      5'd11: begin p = 64'(ua * ub); return p[31:0]; end
      5'd12: begin p = 64'(sa * sb); return p[63:32]; end
      5'd13: begin p = 64'(sa * ub); return p[63:32]; end
      5'd14: begin p = 64'(ua * ub); return p[63:32]; end
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Expected value for a multiply result given as a fixed constant.
  function automatic logic [31:0] mext(input logic [31:0] v);
`ifdef ALU_MEXT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] exp);
    total++;
    assert (result === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, result, exp);
  endtask

  // Present one operation, then check the register one edge later.
  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] op, input logic [31:0] exp);
    @(negedge clock);
    A = a; B = b; ALUCode = op;
    @(posedge clock);
    #1;
    check(tag, exp);
  endtask

  logic [31:0] prev;
  logic [31:0] ra, rb, exp_v;
  logic [4:0]  rop;

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'(0);
      3: return 32'(1);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    total = 0; passed = 0;
    reset = 1'b0; A = '0; B = '0; ALUCode = '0;
    #1;
    check("reset_initial", 32'd0);
    repeat (2) @(posedge clock);
    #1;
    check("reset_held", 32'd0);
    @(negedge clock);
    reset = 1'b1;

    step("add",        32'd9, 32'd4, 5'd0, 32'd13);
    step("sub_neg",    32'd9, 32'd10, 5'd1, 32'hFFFF_FFFF);
    step("sub_negops", 32'(-78), 32'(-901), 5'd1, 32'd823);

    // Asynchronous clear mid-run, between clock edges.
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("reset_async", 32'd0);
    @(posedge clock);
    #1;
    check("reset_hold_edge", 32'd0);
    @(negedge clock);
    reset = 1'b1;

    step("add_after_rst", 32'd9, 32'd4, 5'd0, 32'd13);
    step("slt_ge",      32'd9, 32'd4, 5'd3, 32'd0);
    step("slt_lt",      32'd2, 32'd4, 5'd3, 32'd1);
    step("sltu_big",    32'(-2), 32'd4, 5'd4, 32'd0);
    step("sltu_neg",    32'(-2), 32'(-1), 5'd4, 32'd1);
    step("slt_neg",     32'(-2), 32'(-1), 5'd3, 32'd1);
    step("and",         32'd9, 32'd5, 5'd9, 32'd1);
    step("or",          32'd9, 32'd5, 5'd8, 32'd13);
    step("xor",         32'd9, 32'd5, 5'd5, 32'd12);
    step("cpy",         32'd9, 32'h1234_5000, 5'd10, 32'h1234_5000);
    step("sll",         32'd9, 32'd1, 5'd2, 32'd18);
    step("srl",         32'd9, 32'd3, 5'd6, 32'd1);
    step("sra_neg",     32'(-9), 32'd3, 5'd7, 32'hFFFF_FFFE);
    step("srl_neg",     32'(-9), 32'd3, 5'd6, 32'h1FFF_FFFE);
    step("sra_b35",     32'(-9), 32'd35, 5'd7, 32'hFFFF_FFFE);
    step("sll_b35",     32'd9, 32'd35, 5'd2, 32'd72);
    step("sra_zero",    32'h8000_0001, 32'd32, 5'd7, 32'h8000_0001);
    step("mul",         32'h0001_4C83, 32'hFFFE_8BB0, 5'd11, mext(32'h1C69_BB10));
    step("mulh",        32'h0001_4C83, 32'hFFFE_8BB0, 5'd12, mext(32'hFFFF_FFFE));
    step("mulhu",       32'h0001_4C83, 32'hFFFE_8BB0, 5'd14, mext(32'h0001_4C81));
    step("mulhsu",      32'h0001_4C83, 32'hFFFE_8BB0, 5'd13, mext(32'h0001_4C81));
    step("mulhsu_nega", 32'hFFFE_B37D, 32'hFFFE_8BB0, 5'd13, mext(32'hFFFE_B37E));
    step("unused20",    32'd9, 32'd4, 5'd20, 32'd0);
    step("unused15",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'd0);

    // Back-to-back random ops: the register must hold its previous value
    // until the next edge, then show the new result.
    prev = 32'd0;
    for (int i = 0; i < 400; i++) begin
      ra  = pick_operand();
      rb  = pick_operand();
      rop = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(15, 31))
                                        : 5'($urandom_range(0, 14));
      exp_v = model(ra, rb, rop);
      @(negedge clock);
      A = ra; B = rb; ALUCode = rop;
      if (i > 0) begin
        #1;
        check($sformatf("hold_%0d", i), prev);
      end
      @(posedge clock);
      #1;
      check($sformatf("rand_%0d_op%0d", i, rop), exp_v);
      prev = exp_v;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_rv32im.md
Name: alu_rv32im

Overview:
- Registered integer ALU for the RV32I core with M-extension multiply support.
- Sits in the execute stage; the decoder supplies a 5-bit operation code and two 32-bit operands; the result is captured into an output register on each clock edge.
- Covers add/sub, signed/unsigned compare, logic, shifts, operand copy (LUI path) and MUL/MULH/MULHSU/MULHU.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported; shift amount is B[4:0].

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- A  input  32  operand A (rs1)
- B  input  32  operand B (rs2 or immediate)
- ALUCode  input  5  operation select; encodings in shared package
- result  output  32  registered result

Behaviour:
- reset low: result = 0 immediately (async); held at 0 while low; first capture at first rising clock after release.
- Latency 1: result at edge n+1 reflects A/B/ALUCode sampled at edge n; new operation accepted every cycle; no handshake.
- Encodings: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, CPY=10, MUL=11, MULH=12, MULHSU=13, MULHU=14; codes 15-31 -> result 0.
- ADD/SUB: modulo 2^32; overflow is ignored; no flags.
- SLT: 1 if $signed(A) < $signed(B), else 0. SLTU: same compare, unsigned. Upper 31 bits are 0.
- SLL/SRL/SRA: shift A by B[4:0]; B[31:5] are ignored. SRA sign-fills; a shift of 0 returns A.
- AND/OR/XOR: bitwise.
- CPY: result = B (LUI pass-through); A is ignored.
- MUL: low 32 bits of A*B (identical for signed and unsigned).
- MULH: high 32 of signed x signed. MULHSU: high 32 of signed A x unsigned B. MULHU: high 32 of unsigned x unsigned.
- Multiply is combinational single-cycle, feeding the same output register: 33x33 signed product, with operands extended by their sign bit or by 0 per op.
- All datapath logic is combinational ahead of the single result register; no other state.

Optional Feature:
- Macro ALU_MEXT_EN.
- Defined: MUL/MULH/MULHSU/MULHU are implemented as above.
- Undefined: no multiplier is instantiated; codes 11-14 behave as unused codes (result 0); all other ops are unchanged.

Decomposition:
- Package alu_rv32im_pkg holds:
  - DATA_W constant
  - alu_op_e enum (5-bit) with the encodings above
  - a helper width constant for the shift amount (5)
- Sub-module alu_mul: combinational 32x32 multiplier.
  - Inputs: A, B, a_signed, b_signed.
  - Output: 64-bit product.
  - Instantiated only under ALU_MEXT_EN.

Test Plan:
- Reset low mid-run -> result 0 asynchronously. After release, A=9, B=4, ADD -> 13 one edge later. SUB 9-10 -> 0xFFFFFFFF. SUB A=-78, B=-901 -> 823.
- Compare: A=9, B=4 SLT -> 0; A=2 -> 1. SLTU A=-2, B=4 -> 0. SLTU A=-2, B=-1 -> 1. SLT A=-2, B=-1 -> 1.
- Logic: A=9, B=5 -> AND 1, OR 13, XOR 12. CPY A=9, B=0x12345000 -> 0x12345000.
- Shifts:
  - SLL 9 by 1 -> 18.
  - SRL 9 by 3 -> 1.
  - SRA -9 by 3 -> 0xFFFFFFFE.
  - SRL -9 by 3 -> 0x1FFFFFFE.
  - B=35 behaves as a shift of 3.
- Multiply with A=0x00014C83, B=0xFFFE8BB0:
  - MUL -> 0x1C69BB10, MULH -> 0xFFFFFFFE, MULHU -> 0x00014C81, MULHSU -> 0x00014C81.
  - Then A=0xFFFEB37D: MULHSU -> 0xFFFEB37E.
- Unused ALUCode 20 -> 0. With ALU_MEXT_EN undefined, MUL -> 0. Back-to-back op changes every cycle -> each result appears exactly one edge later.
